// File: rtl/regfile_arbiter_if.sv
// Request/grant and register-file bus between the two requesters, the arbiter and the register file.
// The slave modport is the arbiter; the master modport is the requesters plus the register file's read data.
interface regfile_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic [DATA_W-1:0] rdata1;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] out_reg;
    logic              busy;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output out_reg,
        input  gnt0, rdata0, gnt1, rdata1,
        input  we_reg, addr_reg, data_reg, busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  out_reg,
        output gnt0, rdata0, gnt1, rdata1,
        output we_reg, addr_reg, data_reg, busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter/sequencer for a single-port register file: IDLE -> ACC -> RESP.
// Define RF_ARB_ZERO_PROTECT_EN to suppress the write strobe for writes to the top address.
module regfile_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input logic              clk,
    input logic              rst,
    regfile_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t            state;
    logic              rr_ptr;
    logic              win;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              wr_en;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick = 1'b0;
        if (bus.req0 && bus.req1)
            pick = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
        else if (bus.req1)
            pick = 1'b1;

        sel_we    = pick ? bus.we1    : bus.we0;
        sel_addr  = pick ? bus.addr1  : bus.addr0;
        sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    end

`ifdef RF_ARB_ZERO_PROTECT_EN
    assign wr_en = sel_we && (sel_addr != {ADDR_W{1'b1}});
`else
    assign wr_en = sel_we;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            win          <= 1'b0;
            bus.we_reg   <= 1'b0;
            bus.addr_reg <= '0;
            bus.data_reg <= '0;
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
            bus.busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state        <= ACC;
                        win          <= pick;
                        rr_ptr       <= ~pick;
                        bus.we_reg   <= wr_en;
                        bus.addr_reg <= sel_addr;
                        bus.data_reg <= sel_wdata;
                        bus.busy     <= 1'b1;
                    end
                end
                ACC: begin
                    // The register file writes on this same edge, so out_reg still holds the pre-write value.
                    state      <= RESP;
                    bus.we_reg <= 1'b0;
                    if (win) begin
                        bus.rdata1 <= bus.out_reg;
                        bus.gnt1   <= 1'b1;
                    end else begin
                        bus.rdata0 <= bus.out_reg;
                        bus.gnt0   <= 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus.gnt0 <= 1'b0;
                    bus.gnt1 <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed vector table, reset/arbitration sequences,
// and randomized traffic against a behavioural register-file and arbitration model.
module tb_regfile_arbiter;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int FIXED_PRIO = 0;
`ifdef RF_ARB_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   rf_clr = 1'b1;

    always #5 clk = ~clk;

    regfile_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(FIXED_PRIO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Register file attached to the arbiter: synchronous write, combinational read.
    logic [7:0] rf [16];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (bus.we_reg) begin
            rf[bus.addr_reg] <= bus.data_reg;
        end
    end
    assign bus.out_reg = rf[bus.addr_reg];

    // Behavioural model.
    logic [7:0] ref_mem [16];
    bit         pref;
    logic [7:0] exp_rd [2];
    bit         pend [2];
    bit         op_we [2];
    logic [3:0] op_addr [2];
    logic [7:0] op_data [2];
    logic [7:0] last_rdata;
    logic       last_acc_we;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         rq;
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_we;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int id, input bit req, input bit we, input logic [3:0] a, input logic [7:0] d);
        if (id == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic start_req(input int id, input bit we, input logic [3:0] a, input logic [7:0] d);
        op_we[id]   = we;
        op_addr[id] = a;
        op_data[id] = d;
        pend[id]    = 1'b1;
        drive(id, 1'b1, we, a, d);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
        #1;
        check({tag, "_we_reg"},   bus.we_reg,   0);
        check({tag, "_addr_reg"}, bus.addr_reg, 0);
        check({tag, "_data_reg"}, bus.data_reg, 0);
        check({tag, "_gnt"},      {bus.gnt1, bus.gnt0}, 0);
        check({tag, "_rdata0"},   bus.rdata0,   0);
        check({tag, "_rdata1"},   bus.rdata1,   0);
        check({tag, "_busy"},     bus.busy,     0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        rf_clr    = 1'b0;
        pref      = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
    endtask

    // Serves every pending request, predicting the winner and results from the model.
    task automatic serve_all();
        int         cyc;
        int         w;
        bit         got;
        bit         a_seen;
        logic       a_we;
        logic [3:0] a_addr;
        logic [7:0] a_data;
        logic [7:0] pre;
        bit         ewe;
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) w = (FIXED_PRIO != 0) ? 0 : int'(pref);
            else                    w = pend[0] ? 0 : 1;
            cyc = 0; got = 1'b0; a_seen = 1'b0;
            a_we = 1'bx; a_addr = 'x; a_data = 'x;
            while (!got && cyc < 8) begin
                @(posedge clk); #1; cyc++;
                if (bus.gnt0 || bus.gnt1) got = 1'b1;
                else if (bus.busy) begin
                    a_seen = 1'b1; a_we = bus.we_reg; a_addr = bus.addr_reg; a_data = bus.data_reg;
                end
            end
            if (!got) begin
                check("gnt_timeout", 0, 1);
                drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
                drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
                pend[0] = 1'b0; pend[1] = 1'b0;
                return;
            end
            pre = ref_mem[op_addr[w]];
            ewe = op_we[w] && !(ZP && op_addr[w] == 4'hF);
            check("latency",      cyc, 2);
            check("acc_seen",     a_seen, 1);
            check("gnt_winner",   {bus.gnt1, bus.gnt0}, (w == 1) ? 2'b10 : 2'b01);
            check("rdata_winner", (w == 1) ? bus.rdata1 : bus.rdata0, pre);
            check("rdata_other",  (w == 1) ? bus.rdata0 : bus.rdata1, exp_rd[1-w]);
            check("acc_we",       a_we, ewe);
            check("acc_addr",     a_addr, op_addr[w]);
            check("acc_data",     a_data, op_data[w]);
            check("resp_we_reg",  bus.we_reg, 0);
            check("resp_busy",    bus.busy, 1);
            last_rdata  = (w == 1) ? bus.rdata1 : bus.rdata0;
            last_acc_we = a_we;
            exp_rd[w] = pre;
            if (ewe) ref_mem[op_addr[w]] = op_data[w];
            pref = (w == 0);
            drive(w, 1'b0, 1'b0, 4'h0, 8'h00);
            pend[w] = 1'b0;
            @(posedge clk); #1;
            check("gnt_one_cycle", {bus.gnt1, bus.gnt0}, 0);
            check("idle_busy",     bus.busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre3;
        int         cyc;
        int         w;
        bit         got;
        int         r;

        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
        #2;
        apply_reset("reset");

        // Directed vector table, applied from reset with an all-zero register file.
        vecs[0] = '{rq: 1'b0, we: 1'b1, addr: 4'd1,  wdata: 8'h5A, exp_rdata: 8'h00, exp_we: 1'b1};
        vecs[1] = '{rq: 1'b0, we: 1'b0, addr: 4'd1,  wdata: 8'h00, exp_rdata: 8'h5A, exp_we: 1'b0};
        vecs[2] = '{rq: 1'b1, we: 1'b1, addr: 4'd2,  wdata: 8'h11, exp_rdata: 8'h00, exp_we: 1'b1};
        vecs[3] = '{rq: 1'b1, we: 1'b1, addr: 4'd2,  wdata: 8'h33, exp_rdata: 8'h11, exp_we: 1'b1};
        vecs[4] = '{rq: 1'b1, we: 1'b0, addr: 4'd2,  wdata: 8'h00, exp_rdata: 8'h33, exp_we: 1'b0};
        vecs[5] = '{rq: 1'b0, we: 1'b1, addr: 4'd15, wdata: 8'hFF, exp_rdata: 8'h00, exp_we: !ZP};
        vecs[6] = '{rq: 1'b1, we: 1'b0, addr: 4'd15, wdata: 8'h00, exp_rdata: ZP ? 8'h00 : 8'hFF, exp_we: 1'b0};
        vecs[7] = '{rq: 1'b0, we: 1'b0, addr: 4'd2,  wdata: 8'h00, exp_rdata: 8'h33, exp_we: 1'b0};
        vecs[8] = '{rq: 1'b1, we: 1'b0, addr: 4'd1,  wdata: 8'h00, exp_rdata: 8'h5A, exp_we: 1'b0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start_req(int'(vecs[i].rq), vecs[i].we, vecs[i].addr, vecs[i].wdata);
            serve_all();
            check("tbl_rdata", last_rdata, vecs[i].exp_rdata);
            check("tbl_we",    last_acc_we, vecs[i].exp_we);
        end

        // Reset asserted in the middle of a write's ACC cycle: the write is abandoned.
        pre3 = ref_mem[3];
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'd3, 8'hC3);
        @(posedge clk); #1;
        check("t6_acc_we",   bus.we_reg, 1);
        check("t6_acc_busy", bus.busy, 1);
        @(negedge clk);
        apply_reset("t6");
        check("t6_no_write", rf[3], pre3);
        @(negedge clk);
        start_req(0, 1'b0, 4'd3, 8'h00);
        serve_all();
        check("t6_read_back", last_rdata, pre3);

        // Both requesters held high together: grant order from a fresh pointer.
        @(negedge clk);
        apply_reset("t3");
        @(negedge clk);
        op_we[0] = 1'b0; op_addr[0] = 4'd1; op_data[0] = 8'h00;
        op_we[1] = 1'b0; op_addr[1] = 4'd2; op_data[1] = 8'h00;
        drive(0, 1'b1, 1'b0, 4'd1, 8'h00);
        drive(1, 1'b1, 1'b0, 4'd2, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cyc = 0; got = 1'b0;
            while (!got && cyc < 8) begin
                @(posedge clk); #1; cyc++;
                got = bus.gnt0 || bus.gnt1;
            end
            if (!got) begin
                check("t3_timeout", 0, 1);
                break;
            end
            w = bus.gnt1 ? 1 : 0;
            check("t3_order", w, (FIXED_PRIO != 0) ? 0 : (k % 2));
            check("t3_rdata", (w == 1) ? bus.rdata1 : bus.rdata0, ref_mem[op_addr[w]]);
            exp_rd[w] = ref_mem[op_addr[w]];
            pref = (w == 0);
            if (k == 3) begin
                drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
                drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
            end
        end
        @(posedge clk); #1;
        check("t3_idle_gnt", {bus.gnt1, bus.gnt0}, 0);

        // Randomized traffic: one or both requesters per round.
        for (int it = 0; it < 150; it++) begin
            @(negedge clk);
            r = int'($urandom_range(1, 3));
            if (r[0]) start_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if (r[1]) start_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            serve_all();
        end

        for (int i = 0; i < 16; i++) check("rf_final", rf[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
